// File: rtl/writeback_arbiter_if.sv
// Writeback bundle between the pipeline/MDU producers, the arbiter and the register file.
// The master modport is the producer/consumer side and the slave modport is the arbiter.
interface writeback_arbiter_if;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        pipe_stall;
  logic [31:0] busy;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready, pipe_stall, busy,
    input  we3, wa3, wd3
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  mdu_valid, mdu_rd, mdu_data,
    output mdu_ready, pipe_stall, busy,
    output we3, wa3, wd3
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Single-port register-file writeback arbiter: the pipeline has priority, multi-cycle
// results wait in an in-order FIFO and force a pipe stall once starved long enough.
module writeback_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                reset,
  writeback_arbiter_if.slave wb
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   entry_busy [DEPTH];
  logic [31:0]   busy_all;

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic          we3_reg, we3_next;
  logic [4:0]    wa3_reg, wa3_next;
  logic [31:0]   wd3_reg, wd3_next;

  logic fifo_empty;
  logic fifo_full;
  logic stall;
  logic pipe_win;
  logic push;
  logic pop;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);

  // Ready comes only from the registered count so it never depends on this cycle's pop.
  assign stall    = !reset && (starve_reg == STARVE_TOP);
  assign pipe_win = !stall && wb.pipe_valid && (wb.pipe_rd != 5'd0);
  assign pop      = !fifo_empty && (stall || !pipe_win);
  assign push     = !reset && !fifo_full && wb.mdu_valid && (wb.mdu_rd != 5'd0);

  assign wb.mdu_ready  = !reset && !fifo_full;
  assign wb.pipe_stall = stall;
  assign wb.we3        = we3_reg;
  assign wb.wa3        = wa3_reg;
  assign wb.wd3        = wd3_reg;

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    starve_next = starve_reg;
    we3_next    = 1'b0;
    wa3_next    = wa3_reg;
    wd3_next    = wd3_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    if (pop || fifo_empty) begin
      starve_next = '0;
    end else if (starve_reg != STARVE_TOP) begin
      starve_next = starve_reg + SW'(1);
    end

    if (pipe_win) begin
      we3_next = 1'b1;
      wa3_next = wb.pipe_rd;
      wd3_next = wb.pipe_data;
    end else if (pop) begin
      we3_next = 1'b1;
      wa3_next = rd_mem[rd_ptr_reg];
      wd3_next = data_mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
      we3_reg    <= 1'b0;
      wa3_reg    <= '0;
      wd3_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      starve_reg <= starve_next;
      we3_reg    <= we3_next;
      wa3_reg    <= wa3_next;
      wd3_reg    <= wd3_next;
    end
  end

  // Storage needs no reset: liveness of each slot is derived from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= wb.mdu_rd;
      data_mem[wr_ptr_reg] <= wb.mdu_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
    logic [AW-1:0] offset;
    logic          live;
    assign offset         = AW'(gi) - rd_ptr_reg;
    assign live           = ({1'b0, offset} < count_reg);
    assign entry_busy[gi] = live ? (32'd1 << rd_mem[gi]) : 32'd0;
  end

  always_comb begin
    busy_all = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_all = busy_all | entry_busy[i];
    end
  end

  assign wb.busy = reset ? 32'd0 : (busy_all & ~32'd1);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: constant vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_arbiter_if wbif ();

  writeback_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wbif)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        x_ready;
    logic        x_stall;
    logic [31:0] x_busy;
    logic        x_we;
    logic [4:0]  x_wa;
    logic [31:0] x_wd;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state: queued MDU results, starvation age and expected write port.
  ent_t        q[$];
  int          starve = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;

  logic        obs_ready;
  logic        obs_stall;
  logic [31:0] obs_busy;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic pv, input logic [4:0] prd,
                       input logic [31:0] pdata, input logic mv, input logic [4:0] mrd,
                       input logic [31:0] mdata);
    logic        e_ready;
    logic        e_stall;
    logic        win;
    logic        popped;
    logic [31:0] e_busy;
    reset           = rst;
    wbif.pipe_valid = pv;
    wbif.pipe_rd    = prd;
    wbif.pipe_data  = pdata;
    wbif.mdu_valid  = mv;
    wbif.mdu_rd     = mrd;
    wbif.mdu_data   = mdata;
    #1;
    e_ready = !rst && (q.size() < DEPTH);
    e_stall = !rst && (starve == STARVE_MAX);
    e_busy  = '0;
    if (!rst) begin
      foreach (q[i]) e_busy = e_busy | (32'd1 << q[i].rd);
    end
    e_busy[0] = 1'b0;
    obs_ready = wbif.mdu_ready;
    obs_stall = wbif.pipe_stall;
    obs_busy  = wbif.busy;
    chk("mdu_ready", {31'd0, obs_ready}, {31'd0, e_ready});
    chk("pipe_stall", {31'd0, obs_stall}, {31'd0, e_stall});
    chk("busy", obs_busy, e_busy);

    if (rst) begin
      q.delete();
      starve = 0;
      m_we   = 1'b0;
      m_wa   = '0;
      m_wd   = '0;
    end else begin
      win    = !e_stall && pv && (prd != 5'd0);
      popped = (q.size() > 0) && (e_stall || !win);
      if (win) begin
        m_we = 1'b1; m_wa = prd; m_wd = pdata;
      end else if (popped) begin
        m_we = 1'b1; m_wa = q[0].rd; m_wd = q[0].data;
      end else begin
        m_we = 1'b0;
      end
      if (popped || q.size() == 0) starve = 0;
      else if (starve < STARVE_MAX) starve++;
      if (popped) void'(q.pop_front());
      if (mv && e_ready && mrd != 5'd0) q.push_back('{rd: mrd, data: mdata});
    end

    @(posedge clk);
    #1;
    chk("we3", {31'd0, wbif.we3}, {31'd0, m_we});
    chk("wa3", {27'd0, wbif.wa3}, {27'd0, m_wa});
    chk("wd3", wbif.wd3, m_wd);
    if (wbif.we3) $display("write r%0d = %h at %0t", wbif.wa3, wbif.wd3, $time);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    wbif.pipe_valid = 1'b0;
    wbif.pipe_rd    = '0;
    wbif.pipe_data  = '0;
    wbif.mdu_valid  = 1'b0;
    wbif.mdu_rd     = '0;
    wbif.mdu_data   = '0;

    //          rst  pv   prd   pdata          mv   mrd   mdata        rdy  stl  busy        we   wa    wd
    tbl[0]  = '{1'b1,1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,       1'b0,1'b0,32'h0,      1'b0,5'd0, 32'h0};
    tbl[1]  = '{1'b0,1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,       1'b1,1'b0,32'h0,      1'b0,5'd0, 32'h0};
    tbl[2]  = '{1'b0,1'b1,5'd5, 32'hDEADBEEF,  1'b0,5'd0, 32'h0,       1'b1,1'b0,32'h0,      1'b1,5'd5, 32'hDEADBEEF};
    tbl[3]  = '{1'b0,1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,       1'b1,1'b0,32'h0,      1'b0,5'd5, 32'hDEADBEEF};
    tbl[4]  = '{1'b0,1'b0,5'd0, 32'h0,         1'b1,5'd7, 32'h12345678,1'b1,1'b0,32'h0,      1'b0,5'd5, 32'hDEADBEEF};
    tbl[5]  = '{1'b0,1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,       1'b1,1'b0,32'h80,     1'b1,5'd7, 32'h12345678};
    tbl[6]  = '{1'b0,1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,       1'b1,1'b0,32'h0,      1'b0,5'd7, 32'h12345678};
    tbl[7]  = '{1'b0,1'b1,5'd0, 32'hAAAA,      1'b1,5'd0, 32'h5555,    1'b1,1'b0,32'h0,      1'b0,5'd7, 32'h12345678};
    tbl[8]  = '{1'b0,1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,       1'b1,1'b0,32'h0,      1'b0,5'd7, 32'h12345678};
    tbl[9]  = '{1'b0,1'b0,5'd0, 32'h0,         1'b1,5'd3, 32'h33,      1'b1,1'b0,32'h0,      1'b0,5'd7, 32'h12345678};
    tbl[10] = '{1'b0,1'b1,5'd0, 32'h0BAD,      1'b0,5'd0, 32'h0,       1'b1,1'b0,32'h8,      1'b1,5'd3, 32'h33};
    tbl[11] = '{1'b0,1'b1,5'd4, 32'h44,        1'b1,5'd6, 32'h66,      1'b1,1'b0,32'h0,      1'b1,5'd4, 32'h44};
    tbl[12] = '{1'b0,1'b1,5'd8, 32'h88,        1'b0,5'd0, 32'h0,       1'b1,1'b0,32'h40,     1'b1,5'd8, 32'h88};
    tbl[13] = '{1'b0,1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,       1'b1,1'b0,32'h40,     1'b1,5'd6, 32'h66};
    tbl[14] = '{1'b0,1'b0,5'd0, 32'h0,         1'b0,5'd0, 32'h0,       1'b1,1'b0,32'h0,      1'b0,5'd6, 32'h66};

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].rst, tbl[i].pv, tbl[i].prd, tbl[i].pdata, tbl[i].mv, tbl[i].mrd, tbl[i].mdata);
      chk($sformatf("vec%0d_ready", i), {31'd0, obs_ready}, {31'd0, tbl[i].x_ready});
      chk($sformatf("vec%0d_stall", i), {31'd0, obs_stall}, {31'd0, tbl[i].x_stall});
      chk($sformatf("vec%0d_busy", i), obs_busy, tbl[i].x_busy);
      chk($sformatf("vec%0d_we3", i), {31'd0, wbif.we3}, {31'd0, tbl[i].x_we});
      chk($sformatf("vec%0d_wa3", i), {27'd0, wbif.wa3}, {27'd0, tbl[i].x_wa});
      chk($sformatf("vec%0d_wd3", i), wbif.wd3, tbl[i].x_wd);
    end

    // Backpressure and starvation: pipe writes every cycle, three MDU offers back to back.
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 1'b1, 5'(k + 1), 32'hC000_0000 + k, (k < 3), 5'(9 + k), 32'h9000_0000 + k);
      if (k < 2) chk($sformatf("bp_ready_k%0d", k), {31'd0, obs_ready}, 32'd1);
      if (k == 2) chk("bp_third_ready", {31'd0, obs_ready}, 32'd0);
      chk($sformatf("starve_stall_k%0d", k), {31'd0, obs_stall}, {31'd0, (k == 5 || k == 10)});
      if (k == 5) begin
        chk("starve_first_wa3", {27'd0, wbif.wa3}, 32'd9);
        chk("starve_first_wd3", wbif.wd3, 32'h9000_0000);
      end
      if (k == 10) begin
        chk("starve_second_wa3", {27'd0, wbif.wa3}, 32'd10);
        chk("starve_second_wd3", wbif.wd3, 32'h9000_0001);
      end
    end

    // Reset while two entries are queued and a pipe write is pending.
    cycle(1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd12, 32'hC12);
    cycle(1'b0, 1'b1, 5'd2, 32'hA2, 1'b1, 5'd13, 32'hC13);
    chk("rstmid_busy_before", obs_busy, 32'h1000);
    cycle(1'b1, 1'b1, 5'd3, 32'hA3, 1'b0, 5'd0, 32'h0);
    chk("rstmid_we3_after_reset", {31'd0, wbif.we3}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      chk($sformatf("rstmid_busy_k%0d", k), obs_busy, 32'd0);
      chk($sformatf("rstmid_ready_k%0d", k), {31'd0, obs_ready}, 32'd1);
      chk($sformatf("rstmid_we3_k%0d", k), {31'd0, wbif.we3}, 32'd0);
    end

    // Randomized traffic, mostly busy pipe so the FIFO fills and starves.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] prd;
      logic [4:0] mrd;
      prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), prd, $urandom,
            ($urandom_range(0, 1) == 1), mrd, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter: DEPTH, 2, number of entries in the MDU result FIFO (power of two, >=2).
REQ-002 Parameter: STARVE_MAX, 4, consecutive blocked cycles before the FIFO head forces a pipe stall (>=1).
REQ-003 The clock is clk and the reset is reset; one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 pipe_valid  input  1  single-cycle pipeline result valid this cycle.
REQ-007 pipe_rd  input  5  pipeline destination register.
REQ-008 pipe_data  input  32  pipeline result.
REQ-009 mdu_valid  input  1  multi-cycle unit offers a result.
REQ-010 mdu_rd  input  5  MDU destination register.
REQ-011 mdu_data  input  32  MDU result.
REQ-012 mdu_ready  output  1  FIFO can accept an MDU result this cycle.
REQ-013 pipe_stall  output  1  upstream holds its writeback this cycle; pipe input ignored.
REQ-014 busy  output  32  bit r set while any FIFO entry targets register r.
REQ-015 we3  output  1  register-file write enable (registered).
REQ-016 wa3  output  5  register-file write address (registered).
REQ-017 wd3  output  32  register-file write data (registered).

Function
REQ-018 we3/wa3/wd3 SHALL be registered; a winner selected in cycle N appears on them in cycle N+1 for exactly one cycle unless another winner is selected.
REQ-019 Selection per cycle SHALL be: if pipe_stall=1, pop FIFO head; else if pipe_valid=1 and pipe_rd!=0, pipe wins; else if FIFO non-empty, pop head; else no write (we3=0 next cycle, wa3/wd3 hold).
REQ-020 pipe_valid=1 with pipe_rd=0 SHALL produce no write and SHALL allow a FIFO pop that cycle.
REQ-021 mdu_ready SHALL equal (count<DEPTH) from registered count, independent of a same-cycle pop; no combinational pass-through.
REQ-022 An MDU transfer SHALL occur when mdu_valid=1 and mdu_ready=1; mdu_rd=0 transfers SHALL be accepted and discarded (not enqueued).
REQ-023 FIFO SHALL be strictly in-order; push and pop in the same cycle SHALL leave count unchanged.
REQ-024 Minimum MDU latency: accept in cycle N -> we3=1 in cycle N+2 (no bypass of empty FIFO).
REQ-025 Pipeline latency: accepted in cycle N -> we3=1 in cycle N+1.
REQ-026 busy SHALL be combinational from FIFO contents; busy[0] SHALL always be 0; an entry's bit clears the cycle after it is popped.
REQ-027 starve_cnt SHALL increment each cycle the FIFO is non-empty and not popped, saturating at STARVE_MAX, and clear on any pop or when empty.
REQ-028 pipe_stall SHALL be 1 exactly when starve_cnt==STARVE_MAX, forcing a pop that cycle; the pipe input present in that cycle SHALL NOT be written.
REQ-029 No ordering is enforced between sources; the hazard unit SHALL use busy to prevent same-register conflicts.

Reset
REQ-030 While reset=1: we3=0, wa3=0, wd3=0, FIFO count=0, starve_cnt=0, busy=0, pipe_stall=0, mdu_ready=0.
REQ-031 The first cycle after reset deasserts, mdu_ready SHALL be 1 and we3 SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all FIFO entries and any pending output write in the same edge.

Verification
REQ-033 Pipe only: pipe_valid=1, rd=5, data=0xDEADBEEF in cycle 1 -> we3=1, wa3=5, wd3=0xDEADBEEF in cycle 2, we3=0 in cycle 3.
REQ-034 MDU on idle: mdu rd=7, data=0x12345678 accepted cycle 1 -> busy[7]=1 cycle 2, we3=1/wa3=7 cycle 3, busy[7]=0 cycle 3.
REQ-035 Backpressure: DEPTH=2, pipe_valid=1 rd!=0 every cycle, three MDU offers -> two accepted, mdu_ready=0 on third, FIFO head written only via pipe_stall.
REQ-036 Starvation: FIFO holds rd=9, pipe busy every cycle -> pipe_stall=1 exactly STARVE_MAX(4) cycles after entry, we3/wa3=9 next cycle, pipe input of stall cycle not written.
REQ-037 Zero-register: pipe rd=0 and mdu rd=0 -> no we3 pulse, busy stays 0, FIFO count stays 0.
REQ-038 Reset mid-flight: two entries queued, reset=1 one cycle -> busy=0, we3=0, mdu_ready=1 next cycle, queued entries never written.
